// File: rtl/cache_line_array.sv
// ---------------------------------------------------------------------------
// cache_line_array
//
// Purpose:
//    Direct-mapped array of LINES coherence cache entries. Each entry holds a
//    coherence state, an owner ID, an address tag and one data word. One
//    request is served at a time: lookup (READ), install (WRITE), INVALIDATE
//    and state/owner UPDATE. A dirty (Modified) victim displaced by a WRITE,
//    or a Modified line being invalidated, is first pushed out through the
//    valid/ready write-back port.
//
//    State encoding: 00 Invalid, 01 Shared, 10 Modified (dirty), 11 Exclusive.
//
// Ports:
//    clock, reset              rising-edge clock, asynchronous active-high reset
//    req_valid / req_ready     request handshake (accepted only in IDLE)
//    req_op                    00 READ, 01 WRITE, 10 INVALIDATE, 11 UPDATE
//    req_address               {tag, index}; index = low log2(LINES) bits
//    req_state/owner/data      values to install or update
//    rsp_valid                 one-cycle response pulse
//    rsp_hit/state/owner/data  entry contents as found at lookup
//    wb_valid / wb_ready       victim write-back handshake
//    wb_address / wb_data      victim {tag, index} and data
//
// Optional feature (macro CACHE_LINE_STATS_EN):
//    Adds 8-bit saturating outputs hit_count and miss_count, updated once per
//    request at lookup time.
// ---------------------------------------------------------------------------
module cache_line_array #(
   parameter int LINES   = 4,
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 4,
   parameter int OWNER_W = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_op,
   input  logic [ADDR_W-1:0]  req_address,
   input  logic [1:0]         req_state,
   input  logic [OWNER_W-1:0] req_owner,
   input  logic [DATA_W-1:0]  req_data,
   output logic               rsp_valid,
   output logic               rsp_hit,
   output logic [1:0]         rsp_state,
   output logic [OWNER_W-1:0] rsp_owner,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               wb_valid,
   input  logic               wb_ready,
   output logic [ADDR_W-1:0]  wb_address,
   output logic [DATA_W-1:0]  wb_data
`ifdef CACHE_LINE_STATS_EN
   ,
   output logic [7:0]         hit_count,
   output logic [7:0]         miss_count
`endif
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_INV   = 2'b10;
   localparam logic [1:0] OP_UPD   = 2'b11;

   localparam logic [1:0] ST_INV = 2'b00;
   localparam logic [1:0] ST_MOD = 2'b10;

   // FETCH is the registered array read; it gives the fixed three-cycle
   // turnaround from accept to response.
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOOKUP,
      S_WRITEBACK,
      S_RESPOND
   } fsm_t;

   fsm_t r_fsm;
   fsm_t w_fsm_next;

   // Latched request
   logic [1:0]         r_op;
   logic [IDX_W-1:0]   r_index;
   logic [TAG_W-1:0]   r_tag;
   logic [1:0]         r_new_state;
   logic [OWNER_W-1:0] r_new_owner;
   logic [DATA_W-1:0]  r_new_data;

   // Line storage
   logic [1:0]         r_line_state [LINES];
   logic [OWNER_W-1:0] r_line_owner [LINES];
   logic [TAG_W-1:0]   r_line_tag   [LINES];
   logic [DATA_W-1:0]  r_line_data  [LINES];

   // Registered read of the indexed entry
   logic [1:0]         r_rd_state;
   logic [OWNER_W-1:0] r_rd_owner;
   logic [TAG_W-1:0]   r_rd_tag;
   logic [DATA_W-1:0]  r_rd_data;

   // Response / write-back registers
   logic               r_rsp_hit;
   logic [1:0]         r_rsp_state;
   logic [OWNER_W-1:0] r_rsp_owner;
   logic [DATA_W-1:0]  r_rsp_data;
   logic [ADDR_W-1:0]  r_wb_address;
   logic [DATA_W-1:0]  r_wb_data;

   logic               w_hit;
   logic               w_need_wb;
   logic               w_act;
   logic               w_commit;
   logic [1:0]         w_wr_state;
   logic [OWNER_W-1:0] w_wr_owner;
   logic [TAG_W-1:0]   w_wr_tag;
   logic [DATA_W-1:0]  w_wr_data;

   assign w_hit = (r_rd_state != ST_INV) && (r_rd_tag == r_tag);

   // A Modified entry is only ever valid, so the state test alone covers
   // "valid and dirty" for the WRITE victim case.
   assign w_need_wb = ((r_op == OP_WRITE) && (r_rd_state == ST_MOD) && (r_rd_tag != r_tag)) ||
                      ((r_op == OP_INV) && w_hit && (r_rd_state == ST_MOD));

   // Moment at which the request's effect on the array is applied: at lookup
   // when no eviction is needed, otherwise on the write-back handshake.
   assign w_act = ((r_fsm == S_LOOKUP) && !w_need_wb) ||
                  ((r_fsm == S_WRITEBACK) && wb_ready);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_fsm <= S_IDLE;
      end else begin
         r_fsm <= w_fsm_next;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      w_fsm_next = r_fsm;
      unique case (r_fsm)
         S_IDLE:      if (req_valid) w_fsm_next = S_FETCH;
         S_FETCH:     w_fsm_next = S_LOOKUP;
         S_LOOKUP:    w_fsm_next = w_need_wb ? S_WRITEBACK : S_RESPOND;
         S_WRITEBACK: if (wb_ready) w_fsm_next = S_RESPOND;
         S_RESPOND:   w_fsm_next = S_IDLE;
         default:     w_fsm_next = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // req_ready is gated by reset directly so it is low for the whole time
   // reset is asserted, not just from the first edge after release.
   always_comb begin
      req_ready = (r_fsm == S_IDLE) && !reset;
      rsp_valid = (r_fsm == S_RESPOND);
      wb_valid  = (r_fsm == S_WRITEBACK);
   end

   assign rsp_hit    = r_rsp_hit;
   assign rsp_state  = r_rsp_state;
   assign rsp_owner  = r_rsp_owner;
   assign rsp_data   = r_rsp_data;
   assign wb_address = r_wb_address;
   assign wb_data    = r_wb_data;

   // ---------------- Entry update selection ----------------
   // Unchanged fields are rewritten from the fetched copy, which is still
   // current because only this request can modify the array.
   always_comb begin
      w_commit   = 1'b0;
      w_wr_state = r_rd_state;
      w_wr_owner = r_rd_owner;
      w_wr_tag   = r_rd_tag;
      w_wr_data  = r_rd_data;
      if (w_act) begin
         unique case (r_op)
            OP_WRITE: begin
               w_commit   = 1'b1;
               w_wr_state = r_new_state;
               w_wr_owner = r_new_owner;
               w_wr_tag   = r_tag;
               w_wr_data  = r_new_data;
            end
            OP_INV: begin
               if (w_hit) begin
                  w_commit   = 1'b1;
                  w_wr_state = ST_INV;
               end
            end
            OP_UPD: begin
               if (w_hit) begin
                  w_commit   = 1'b1;
                  w_wr_state = r_new_state;
                  w_wr_owner = r_new_owner;
               end
            end
            default: ; // READ leaves the entry untouched
         endcase
      end
   end

   // ---------------- Line storage ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LINES; i++) begin
            r_line_state[i] <= '0;
            r_line_owner[i] <= '0;
            r_line_tag[i]   <= '0;
            r_line_data[i]  <= '0;
         end
      end else if (w_commit) begin
         r_line_state[r_index] <= w_wr_state;
         r_line_owner[r_index] <= w_wr_owner;
         r_line_tag[r_index]   <= w_wr_tag;
         r_line_data[r_index]  <= w_wr_data;
      end
   end

   // ---------------- Request latch, read, response, write-back ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_op         <= '0;
         r_index      <= '0;
         r_tag        <= '0;
         r_new_state  <= '0;
         r_new_owner  <= '0;
         r_new_data   <= '0;
         r_rd_state   <= '0;
         r_rd_owner   <= '0;
         r_rd_tag     <= '0;
         r_rd_data    <= '0;
         r_rsp_hit    <= 1'b0;
         r_rsp_state  <= '0;
         r_rsp_owner  <= '0;
         r_rsp_data   <= '0;
         r_wb_address <= '0;
         r_wb_data    <= '0;
      end else begin
         if ((r_fsm == S_IDLE) && req_valid) begin
            r_op        <= req_op;
            r_index     <= req_address[IDX_W-1:0];
            r_tag       <= req_address[ADDR_W-1:IDX_W];
            r_new_state <= req_state;
            r_new_owner <= req_owner;
            r_new_data  <= req_data;
         end
         if (r_fsm == S_FETCH) begin
            r_rd_state <= r_line_state[r_index];
            r_rd_owner <= r_line_owner[r_index];
            r_rd_tag   <= r_line_tag[r_index];
            r_rd_data  <= r_line_data[r_index];
         end
         if (r_fsm == S_LOOKUP) begin
            // Report the stored entry even on a miss; only rsp_hit tells.
            r_rsp_hit   <= w_hit;
            r_rsp_state <= r_rd_state;
            r_rsp_owner <= r_rd_owner;
            r_rsp_data  <= r_rd_data;
            if (w_need_wb) begin
               r_wb_address <= {r_rd_tag, r_index};
               r_wb_data    <= r_rd_data;
            end
         end
      end
   end

`ifdef CACHE_LINE_STATS_EN
   logic [7:0] r_hit_count;
   logic [7:0] r_miss_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else if (r_fsm == S_LOOKUP) begin
         if (w_hit) begin
            if (r_hit_count != 8'hFF) r_hit_count <= r_hit_count + 8'd1;
         end else begin
            if (r_miss_count != 8'hFF) r_miss_count <= r_miss_count + 8'd1;
         end
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_line_array.sv
// ---------------------------------------------------------------------------
// tb_cache_line_array
//
// Directed bench for cache_line_array with default parameters (LINES=4,
// ADDR_W=3, DATA_W=4, OWNER_W=2): index = addr[1:0], tag = addr[2].
// Build with +define+CACHE_LINE_STATS_EN to exercise the counters.
// ---------------------------------------------------------------------------
module tb_cache_line_array;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_op = '0;
   logic [2:0] req_address = '0;
   logic [1:0] req_state = '0;
   logic [1:0] req_owner = '0;
   logic [3:0] req_data = '0;
   logic       rsp_valid;
   logic       rsp_hit;
   logic [1:0] rsp_state;
   logic [1:0] rsp_owner;
   logic [3:0] rsp_data;
   logic       wb_valid;
   logic       wb_ready = 1'b0;
   logic [2:0] wb_address;
   logic [3:0] wb_data;
`ifdef CACHE_LINE_STATS_EN
   logic [7:0] hit_count;
   logic [7:0] miss_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Last response captured by do_req
   logic       got_hit;
   logic [1:0] got_state;
   logic [1:0] got_owner;
   logic [3:0] got_data;

   always #5 clock = ~clock;

   cache_line_array dut (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_address (req_address),
      .req_state   (req_state),
      .req_owner   (req_owner),
      .req_data    (req_data),
      .rsp_valid   (rsp_valid),
      .rsp_hit     (rsp_hit),
      .rsp_state   (rsp_state),
      .rsp_owner   (rsp_owner),
      .rsp_data    (rsp_data),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_address  (wb_address),
      .wb_data     (wb_data)
`ifdef CACHE_LINE_STATS_EN
      ,
      .hit_count   (hit_count),
      .miss_count  (miss_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one request and wait (bounded) for its response. While the DUT
   // holds wb_valid, wb_ready is kept low for 'hold' observed cycles, then
   // raised for one handshake. Victim address/data are checked every cycle.
   task automatic do_req(input logic [1:0] op, input logic [2:0] addr,
                         input logic [1:0] st, input logic [1:0] own,
                         input logic [3:0] dat, input int hold, input bit exp_wb,
                         input logic [2:0] exp_wa, input logic [3:0] exp_wd);
      int lat;
      int wbc;
      bit done;
      lat  = 0;
      wbc  = 0;
      done = 1'b0;
      @(negedge clock);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_op      = op;
      req_address = addr;
      req_state   = st;
      req_owner   = own;
      req_data    = dat;
      req_valid   = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      while (!done && lat < 60) begin
         @(posedge clock);
         #1;
         lat++;
         if (wb_valid) begin
            wbc++;
            if (exp_wb) begin
               check("wb_address", 32'(wb_address), 32'(exp_wa));
               check("wb_data", 32'(wb_data), 32'(exp_wd));
            end
            if (wbc >= hold) wb_ready = 1'b1;
         end else begin
            wb_ready = 1'b0;
         end
         if (rsp_valid) begin
            done      = 1'b1;
            got_hit   = rsp_hit;
            got_state = rsp_state;
            got_owner = rsp_owner;
            got_data  = rsp_data;
         end
      end
      wb_ready = 1'b0;
      check("rsp_seen", 32'(done), 32'd1);
      check("wb_cycles", 32'(wbc), exp_wb ? 32'(hold) : 32'd0);
      check("latency", 32'(lat), exp_wb ? 32'(2 + hold) : 32'd2);
      $display("txn op=%0d addr=%b st=%0d own=%0d data=%h -> hit=%0d state=%0d owner=%0d data=%h lat=%0d wb=%0d",
               op, addr, st, own, dat, got_hit, got_state, got_owner, got_data, lat, wbc);
      @(posedge clock);
      #1;
      check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
      check("back_idle", 32'(req_ready), 32'd1);
   endtask

   task automatic expect_rsp(input string tag, input logic hit, input logic [1:0] st,
                             input logic [1:0] own, input logic [3:0] dat);
      check({tag, "_hit"}, 32'(got_hit), 32'(hit));
      check({tag, "_state"}, 32'(got_state), 32'(st));
      check({tag, "_owner"}, 32'(got_owner), 32'(own));
      check({tag, "_data"}, 32'(got_data), 32'(dat));
   endtask

   initial begin
      // ---- Reset state ----
      @(posedge clock);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // ---- 1: read miss on empty array ----
      do_req(2'b00, 3'b101, 2'b00, 2'd0, 4'h0, 0, 1'b0, 3'b000, 4'h0);
      expect_rsp("t1_read", 1'b0, 2'b00, 2'd0, 4'h0);

      // ---- 2: install, read hit, read other tag ----
      do_req(2'b01, 3'b010, 2'b01, 2'd2, 4'hA, 0, 1'b0, 3'b000, 4'h0);
      expect_rsp("t2_write", 1'b0, 2'b00, 2'd0, 4'h0);
      do_req(2'b00, 3'b010, 2'b00, 2'd0, 4'h0, 0, 1'b0, 3'b000, 4'h0);
      expect_rsp("t2_read_hit", 1'b1, 2'b01, 2'd2, 4'hA);
      do_req(2'b00, 3'b110, 2'b00, 2'd0, 4'h0, 0, 1'b0, 3'b000, 4'h0);
      expect_rsp("t2_read_other", 1'b0, 2'b01, 2'd2, 4'hA);

      // ---- 3: dirty victim eviction with 4-cycle stall ----
      do_req(2'b01, 3'b001, 2'b10, 2'd0, 4'h7, 0, 1'b0, 3'b000, 4'h0);
      do_req(2'b01, 3'b101, 2'b01, 2'd3, 4'h3, 4, 1'b1, 3'b001, 4'h7);
      expect_rsp("t3_evict", 1'b0, 2'b10, 2'd0, 4'h7);
      do_req(2'b00, 3'b101, 2'b00, 2'd0, 4'h0, 0, 1'b0, 3'b000, 4'h0);
      expect_rsp("t3_read", 1'b1, 2'b01, 2'd3, 4'h3);

      // ---- invalid install reads back as a miss ----
      do_req(2'b01, 3'b000, 2'b00, 2'd1, 4'hF, 0, 1'b0, 3'b000, 4'h0);
      do_req(2'b00, 3'b000, 2'b00, 2'd0, 4'h0, 0, 1'b0, 3'b000, 4'h0);
      expect_rsp("inv_install", 1'b0, 2'b00, 2'd1, 4'hF);

      // ---- 4: update, invalidate, invalidate Modified ----
      do_req(2'b11, 3'b010, 2'b11, 2'd1, 4'h0, 0, 1'b0, 3'b000, 4'h0);
      expect_rsp("t4_update", 1'b1, 2'b01, 2'd2, 4'hA);
      do_req(2'b00, 3'b010, 2'b00, 2'd0, 4'h0, 0, 1'b0, 3'b000, 4'h0);
      expect_rsp("t4_read_upd", 1'b1, 2'b11, 2'd1, 4'hA);
      do_req(2'b10, 3'b010, 2'b00, 2'd0, 4'h0, 0, 1'b0, 3'b000, 4'h0);
      expect_rsp("t4_inval", 1'b1, 2'b11, 2'd1, 4'hA);
      do_req(2'b00, 3'b010, 2'b00, 2'd0, 4'h0, 0, 1'b0, 3'b000, 4'h0);
      expect_rsp("t4_read_inv", 1'b0, 2'b00, 2'd1, 4'hA);
      do_req(2'b01, 3'b011, 2'b10, 2'd2, 4'h5, 0, 1'b0, 3'b000, 4'h0);
      do_req(2'b10, 3'b011, 2'b00, 2'd0, 4'h0, 1, 1'b1, 3'b011, 4'h5);
      expect_rsp("t4_inval_mod", 1'b1, 2'b10, 2'd2, 4'h5);
      do_req(2'b00, 3'b011, 2'b00, 2'd0, 4'h0, 0, 1'b0, 3'b000, 4'h0);
      expect_rsp("t4_read_after", 1'b0, 2'b00, 2'd2, 4'h5);

      // ---- 5: reset while in WRITEBACK ----
      do_req(2'b01, 3'b111, 2'b10, 2'd3, 4'h9, 0, 1'b0, 3'b000, 4'h0);
      @(negedge clock);
      req_op      = 2'b01;
      req_address = 3'b011;
      req_state   = 2'b01;
      req_owner   = 2'd0;
      req_data    = 4'h1;
      req_valid   = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      for (int k = 0; k < 20 && !wb_valid; k++) begin
         @(posedge clock);
         #1;
      end
      check("t5_wb_seen", 32'(wb_valid), 32'd1);
      check("t5_wb_address", 32'(wb_address), 32'(3'b111));
      #2;
      reset = 1'b1;
      #1;
      check("t5_wb_valid", 32'(wb_valid), 32'd0);
      check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t5_req_ready", 32'(req_ready), 32'd0);
      check("t5_wb_addr0", 32'(wb_address), 32'd0);
      check("t5_wb_data0", 32'(wb_data), 32'd0);
      @(posedge clock);
      #1;
      check("t5_req_ready_hold", 32'(req_ready), 32'd0);
`ifdef CACHE_LINE_STATS_EN
      check("t5_hit_count_clr", 32'(hit_count), 32'd0);
      check("t5_miss_count_clr", 32'(miss_count), 32'd0);
`endif
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         logic [2:0] a;
         a = 3'(i + 4);
         do_req(2'b00, a, 2'b00, 2'd0, 4'h0, 0, 1'b0, 3'b000, 4'h0);
         expect_rsp("t5_cleared", 1'b0, 2'b00, 2'd0, 4'h0);
      end

`ifdef CACHE_LINE_STATS_EN
      // ---- 6: saturating miss counter (4 misses above plus 296 here) ----
      for (int i = 0; i < 296; i++) begin
         logic [2:0] a;
         a = 3'(i);
         do_req(2'b00, a, 2'b00, 2'd0, 4'h0, 0, 1'b0, 3'b000, 4'h0);
      end
      check("t6_miss_count", 32'(miss_count), 32'd255);
      check("t6_hit_count", 32'(hit_count), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
